airi5c_minmax_unit: RTL and testbench

Parametrised floating-point MIN/MAX unit for the AIRI5C FPU, replacing the fixed single-precision selector. Supports FLEN 32 or 64, an optional output pipeline stage, and a streaming reduction mode. Reduction mode compares each loaded operand against an internal accumulator, so a min/max over a vector costs one `load` per element. Sits beside the comparator and sign-injection units and shares the FPU's `load`/`kill`/`ready` handshake.

---
 rtl/airi5c_minmax_unit.sv | 163 ++++++++++++++++
 tb/tb_airi5c_minmax_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/airi5c_minmax_unit.sv
// FP MIN/MAX with optional output stage and streaming reduction against an accumulator.
// Latency 1 cycle (PIPE=0) or 2 (PIPE=1); no backpressure, one op per cycle, kill clears all state.
module airi5c_minmax_unit #(
  parameter int FLEN  = 32,
  parameter int PIPE  = 0,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             kill,
  input  logic             load,
  input  logic             op_min,
  input  logic             op_max,
  input  logic             reduce,
  input  logic             first,
  input  logic [FLEN-1:0]  a,
  input  logic [FLEN-1:0]  b,
  output logic [FLEN-1:0]  float_out,
  output logic             IV,
  output logic             IV_acc,
  output logic [CNT_W-1:0] elem_cnt,
  output logic             ready
);

  localparam int EXP_W = (FLEN == 64) ? 11 : 8;
  localparam int MAN_W = FLEN - 1 - EXP_W;
  localparam logic [FLEN-1:0]  CNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic is_nan(input logic [FLEN-1:0] x);
    return (&x[FLEN-2:MAN_W]) && (|x[MAN_W-1:0]);
  endfunction

  function automatic logic is_snan(input logic [FLEN-1:0] x);
    return is_nan(x) && !x[MAN_W-1];
  endfunction

  // Total order on non-NaN values; a sign difference alone decides, so -0 < +0.
  function automatic logic lt(input logic [FLEN-1:0] x, input logic [FLEN-1:0] y);
    if (x[FLEN-1] != y[FLEN-1])
      return x[FLEN-1];
    else if (x[FLEN-1])
      return x[FLEN-2:0] > y[FLEN-2:0];
    else
      return x[FLEN-2:0] < y[FLEN-2:0];
  endfunction

  function automatic logic [FLEN-1:0] pair(input logic [FLEN-1:0] x,
                                           input logic [FLEN-1:0] y,
                                           input logic            sel_min);
    logic x_lt_y;
    x_lt_y = lt(x, y);
    if (is_nan(x) && is_nan(y))
      return CNAN;
    else if (is_nan(x))
      return y;
    else if (is_nan(y))
      return x;
    else if (sel_min)
      return x_lt_y ? x : y;
    else
      return x_lt_y ? y : x;
  endfunction

  logic [FLEN-1:0]  acc;
  logic             acc_valid;
  logic [FLEN-1:0]  x_opnd;
  logic             acc_start;
  logic             valid_op;
  logic [FLEN-1:0]  res;
  logic             res_iv;
  logic [FLEN-1:0]  res1;
  logic             iv1;
  logic             rdy1;
  logic             iv_acc_q;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    x_opnd    = reduce ? acc : b;
    acc_start = reduce && (first || !acc_valid);
    valid_op  = op_min || op_max;
    res       = pair(a, x_opnd, op_min);
    res_iv    = is_snan(a) | is_snan(x_opnd);
    if (acc_start) begin
      res    = is_nan(a) ? CNAN : a;
      res_iv = is_snan(a);
    end
  end

  // Accumulator and counters live in the first stage so back-to-back reduce loads see the new acc.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      res1      <= '0;
      iv1       <= 1'b0;
      rdy1      <= 1'b0;
      acc       <= '0;
      acc_valid <= 1'b0;
      iv_acc_q  <= 1'b0;
      cnt_q     <= '0;
    end else if (kill) begin
      res1      <= '0;
      iv1       <= 1'b0;
      rdy1      <= 1'b0;
      acc       <= '0;
      acc_valid <= 1'b0;
      iv_acc_q  <= 1'b0;
      cnt_q     <= '0;
    end else if (load && valid_op) begin
      res1 <= res;
      iv1  <= res_iv;
      rdy1 <= 1'b1;
      if (reduce) begin
        acc       <= res;
        acc_valid <= 1'b1;
        iv_acc_q  <= acc_start ? res_iv : (iv_acc_q | res_iv);
        cnt_q     <= acc_start ? CNT_ONE : ((&cnt_q) ? cnt_q : cnt_q + CNT_ONE);
      end
    end else if (load) begin
      res1 <= '0;
      iv1  <= 1'b0;
      rdy1 <= 1'b0;
    end else begin
      rdy1 <= 1'b0;
    end
  end

  assign IV_acc   = iv_acc_q;
  assign elem_cnt = cnt_q;

  generate
    if (PIPE != 0) begin : g_pipe
      logic [FLEN-1:0] res2;
      logic            iv2;
      logic            rdy2;

      // Stage 1 holds between results, so tracking it every cycle preserves hold behaviour.
      always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
          res2 <= '0;
          iv2  <= 1'b0;
          rdy2 <= 1'b0;
        end else if (kill) begin
          res2 <= '0;
          iv2  <= 1'b0;
          rdy2 <= 1'b0;
        end else begin
          res2 <= res1;
          iv2  <= iv1;
          rdy2 <= rdy1;
        end
      end

      assign float_out = res2;
      assign IV        = iv2;
      assign ready     = rdy2;
    end else begin : g_nopipe
      assign float_out = res1;
      assign IV        = iv1;
      assign ready     = rdy1;
    end
  endgenerate

endmodule

// File: tb/tb_airi5c_minmax_unit.sv
// Directed bench: FLEN32/PIPE0 (CNT_W 8 and 2 share stimulus) and FLEN64/PIPE1.
module tb_airi5c_minmax_unit;

  logic clk = 1'b0;
  logic n_reset;
  always #5 clk = ~clk;

  logic        kill32, load32, min32, max32, red32, first32;
  logic [31:0] a32, b32;
  logic [31:0] fo32, fo32s;
  logic        iv32, iva32, rdy32, iv32s, iva32s, rdy32s;
  logic [7:0]  cnt32;
  logic [1:0]  cnt32s;

  logic        kill64, load64, min64, max64, red64, first64;
  logic [63:0] a64, b64, fo64;
  logic        iv64, iva64, rdy64;
  logic [7:0]  cnt64;

  int checks = 0;
  int failures = 0;

  airi5c_minmax_unit #(.FLEN(32), .PIPE(0), .CNT_W(8)) u32 (
    .clk(clk), .n_reset(n_reset), .kill(kill32), .load(load32), .op_min(min32),
    .op_max(max32), .reduce(red32), .first(first32), .a(a32), .b(b32),
    .float_out(fo32), .IV(iv32), .IV_acc(iva32), .elem_cnt(cnt32), .ready(rdy32));

  airi5c_minmax_unit #(.FLEN(32), .PIPE(0), .CNT_W(2)) u32s (
    .clk(clk), .n_reset(n_reset), .kill(kill32), .load(load32), .op_min(min32),
    .op_max(max32), .reduce(red32), .first(first32), .a(a32), .b(b32),
    .float_out(fo32s), .IV(iv32s), .IV_acc(iva32s), .elem_cnt(cnt32s), .ready(rdy32s));

  airi5c_minmax_unit #(.FLEN(64), .PIPE(1), .CNT_W(8)) u64 (
    .clk(clk), .n_reset(n_reset), .kill(kill64), .load(load64), .op_min(min64),
    .op_max(max64), .reduce(red64), .first(first64), .a(a64), .b(b64),
    .float_out(fo64), .IV(iv64), .IV_acc(iva64), .elem_cnt(cnt64), .ready(rdy64));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic op32(input logic mn, input logic mx, input logic rd, input logic fs,
                      input logic [31:0] aa, input logic [31:0] bb);
    min32 = mn; max32 = mx; red32 = rd; first32 = fs; a32 = aa; b32 = bb;
    load32 = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic idle32();
    load32 = 1'b0; kill32 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic op64(input logic mn, input logic mx, input logic rd, input logic fs,
                      input logic [63:0] aa, input logic [63:0] bb);
    min64 = mn; max64 = mx; red64 = rd; first64 = fs; a64 = aa; b64 = bb;
    load64 = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic idle64();
    load64 = 1'b0; kill64 = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    n_reset = 1'b0;
    kill32 = 0; load32 = 0; min32 = 0; max32 = 0; red32 = 0; first32 = 0; a32 = '0; b32 = '0;
    kill64 = 0; load64 = 0; min64 = 0; max64 = 0; red64 = 0; first64 = 0; a64 = '0; b64 = '0;
    #12;
    chk("rst_fo32", fo32, 0);
    chk("rst_iv32", iv32, 0);
    chk("rst_iva32", iva32, 0);
    chk("rst_cnt32", cnt32, 0);
    chk("rst_rdy32", rdy32, 0);
    chk("rst_fo64", fo64, 0);
    chk("rst_rdy64", rdy64, 0);
    @(negedge clk) n_reset = 1'b1;
    @(posedge clk); #1;

    // Plain pair ops, FLEN 32, PIPE 0
    op32(1, 0, 0, 0, 32'h3f800000, 32'hbf800000);
    chk("min_fo", fo32, 32'hbf800000);
    chk("min_iv", iv32, 0);
    chk("min_rdy", rdy32, 1);
    op32(0, 1, 0, 0, 32'h3f800000, 32'hbf800000);
    chk("max_fo", fo32, 32'h3f800000);
    chk("max_rdy", rdy32, 1);
    idle32();
    chk("idle_rdy", rdy32, 0);
    chk("hold_fo", fo32, 32'h3f800000);
    op32(1, 0, 0, 0, 32'h00000000, 32'h80000000);
    chk("min_zero", fo32, 32'h80000000);
    op32(0, 1, 0, 0, 32'h80000000, 32'h00000000);
    chk("max_zero", fo32, 32'h00000000);
    op32(1, 0, 0, 0, 32'h7f800001, 32'h40000000);
    chk("snan_fo", fo32, 32'h40000000);
    chk("snan_iv", iv32, 1);
    op32(0, 1, 0, 0, 32'h7fc00001, 32'hff800001);
    chk("nan2_fo", fo32, 32'h7fc00000);
    chk("nan2_iv", iv32, 1);

    // Reduction MAX, back-to-back
    op32(0, 1, 1, 1, 32'h40000000, 32'h12345678);
    chk("red1_fo", fo32, 32'h40000000);
    chk("red1_iva", iva32, 0);
    chk("red1_cnt", cnt32, 1);
    op32(0, 1, 1, 0, 32'h7f800001, 32'h0);
    chk("red2_fo", fo32, 32'h40000000);
    chk("red2_iv", iv32, 1);
    chk("red2_iva", iva32, 1);
    chk("red2_cnt", cnt32, 2);
    op32(0, 1, 1, 0, 32'hc0a00000, 32'h0);
    chk("red3_fo", fo32, 32'h40000000);
    chk("red3_iv", iv32, 0);
    chk("red3_iva", iva32, 1);
    chk("red3_cnts", cnt32s, 3);
    op32(0, 1, 1, 0, 32'h40e00000, 32'h0);
    chk("red4_fo", fo32, 32'h40e00000);
    chk("red4_rdy", rdy32, 1);
    chk("red4_cnt", cnt32, 4);
    op32(0, 1, 1, 0, 32'h3f800000, 32'h0);
    chk("red5_fo", fo32, 32'h40e00000);
    chk("red5_cnt", cnt32, 5);
    chk("red5_cnts_sat", cnt32s, 3);

    // Foreign op and plain op leave the accumulator alone
    op32(0, 0, 1, 0, 32'h7f7fffff, 32'h0);
    chk("foreign_fo", fo32, 0);
    chk("foreign_rdy", rdy32, 0);
    chk("foreign_cnt", cnt32, 5);
    op32(1, 0, 0, 0, 32'h40000000, 32'h3f800000);
    chk("plain_fo", fo32, 32'h3f800000);
    chk("plain_cnt", cnt32, 5);
    op32(0, 1, 1, 0, 32'h3f800000, 32'h0);
    chk("red6_fo", fo32, 32'h40e00000);
    chk("red6_cnt", cnt32, 6);
    chk("red6_iva", iva32, 1);

    // Kill clears everything; next reduce behaves as first
    load32 = 1'b0; kill32 = 1'b1;
    @(posedge clk); #1;
    kill32 = 1'b0;
    chk("kill_fo", fo32, 0);
    chk("kill_iva", iva32, 0);
    chk("kill_cnt", cnt32, 0);
    chk("kill_rdy", rdy32, 0);
    op32(0, 1, 1, 0, 32'hc0a00000, 32'h0);
    chk("postkill_fo", fo32, 32'hc0a00000);
    chk("postkill_cnt", cnt32, 1);
    chk("postkill_iva", iva32, 0);
    kill32 = 1'b1;
    op32(1, 0, 0, 0, 32'h3f800000, 32'hbf800000);
    kill32 = 1'b0;
    chk("killload_rdy", rdy32, 0);
    chk("killload_fo", fo32, 0);
    idle32();
    chk("killload_rdy2", rdy32, 0);

    // FLEN 64, PIPE 1
    op64(1, 0, 0, 0, 64'h4000000000000000, 64'h3ff0000000000000);
    chk("p64_rdy_early", rdy64, 0);
    chk("p64_fo_early", fo64, 0);
    idle64();
    chk("p64_rdy", rdy64, 1);
    chk("p64_fo", fo64, 64'h3ff0000000000000);
    chk("p64_iv", iv64, 0);
    idle64();
    chk("p64_rdy_off", rdy64, 0);
    chk("p64_hold", fo64, 64'h3ff0000000000000);
    op64(0, 1, 0, 0, 64'h7ff0000000000001, 64'hfff8000000000000);
    idle64();
    chk("p64_nan_fo", fo64, 64'h7ff8000000000000);
    chk("p64_nan_iv", iv64, 1);

    // Accumulator state is one cycle after load even with PIPE=1
    op64(1, 0, 1, 1, 64'h4000000000000000, 64'h0);
    chk("p64_red1_cnt", cnt64, 1);
    chk("p64_red1_rdy", rdy64, 0);
    op64(1, 0, 1, 0, 64'h3ff0000000000000, 64'h0);
    chk("p64_red2_cnt", cnt64, 2);
    chk("p64_red2_rdy", rdy64, 1);
    chk("p64_red2_fo", fo64, 64'h4000000000000000);
    load64 = 1'b0; kill64 = 1'b1;
    @(posedge clk); #1;
    kill64 = 1'b0;
    chk("p64_kill_rdy", rdy64, 0);
    chk("p64_kill_fo", fo64, 0);
    chk("p64_kill_cnt", cnt64, 0);
    idle64();
    chk("p64_kill_rdy2", rdy64, 0);
    chk("p64_kill_fo2", fo64, 0);
    kill64 = 1'b1;
    op64(1, 0, 0, 0, 64'h4000000000000000, 64'h3ff0000000000000);
    kill64 = 1'b0;
    idle64();
    chk("p64_killload_rdy", rdy64, 0);
    idle64();
    chk("p64_killload_rdy2", rdy64, 0);

    // Asynchronous reset mid-reduction
    op64(1, 0, 1, 1, 64'h3ff0000000000000, 64'h0);
    chk("p64_rst_pre_cnt", cnt64, 1);
    load64 = 1'b0;
    n_reset = 1'b0;
    #2;
    chk("p64_async_cnt", cnt64, 0);
    @(negedge clk) n_reset = 1'b1;
    @(posedge clk); #1;
    op64(1, 0, 1, 0, 64'h4000000000000000, 64'h0);
    chk("p64_rst_first_cnt", cnt64, 1);
    idle64();
    chk("p64_rst_first_fo", fo64, 64'h4000000000000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
